alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL have parameter: XLEN, 32, datapath width of operands and immediate.
REQ-002 The block SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port: in_valid  input  1  upstream holds a decoded instruction.
REQ-005 The block SHALL have port: in_ready  output  1  block can accept; transfer when in_valid & in_ready.
REQ-006 The block SHALL have port: opcode  input  7  instruction bits [6:0].
REQ-007 The block SHALL have port: funct3  input  3  instruction bits [14:12].
REQ-008 The block SHALL have port: funct7  input  7  instruction bits [31:25].
REQ-009 The block SHALL have port: rs1_data  input  XLEN  register-file read data, source 1.
REQ-010 The block SHALL have port: rs2_data  input  XLEN  register-file read data, source 2.
REQ-011 The block SHALL have port: imm  input  XLEN  sign-extended immediate.
REQ-012 The block SHALL have port: flush  input  1  discard all held and incoming instructions.
REQ-013 The block SHALL have port: out_valid  output  1  issue slot holds an instruction for the ALU.
REQ-014 The block SHALL have port: out_ready  input  1  ALU stage consumes; transfer when out_valid & out_ready.
REQ-015 The block SHALL have port: alu_control_lines  output  4  ALU operation code.
REQ-016 The block SHALL have port: operand1  output  XLEN  ALU operand 1.
REQ-017 The block SHALL have port: operand2  output  XLEN  ALU operand 2.
REQ-018 The block SHALL have port: illegal  output  1  issued instruction did not decode to a legal ALU operation.

Function
REQ-019 ALU codes SHALL be: AND 0000, OR 0001, ADD 0010, XOR 0100, SLL 0101, SUB 0110, SRL 0111, SRA 1000, SLT 1001, SLTU 1010.
REQ-020 R-type (opcode 0110011): operand1=rs1_data, operand2=rs2_data; funct3 000->ADD (funct7 0000000) / SUB (0100000); 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL (0000000) / SRA (0100000); 110 OR; 111 AND.
REQ-021 R-type with funct7 other than 0000000, or 0100000 with funct3 not 000/101, SHALL be illegal.
REQ-022 I-type (opcode 0010011): operand1=rs1_data, operand2=imm; funct3 000 SHALL be ADD regardless of funct7; other funct3 mapped as REQ-020.
REQ-023 I-type shifts: funct3 001 requires funct7 0000000; 101 requires 0000000 (SRL) or 0100000 (SRA); operand2 SHALL be {imm[XLEN-1:5]=0, imm[4:0]}; otherwise illegal.
REQ-024 LUI (opcode 0110111): operand1=0, operand2=imm, code ADD.
REQ-025 Any other opcode or illegal case: code ADD, operand1=0, operand2=0, illegal=1; instruction still flows through handshake.
REQ-026 Decode SHALL be combinational on inputs and registered on acceptance; latency 1 cycle from in handshake to out_valid.
REQ-027 Storage SHALL be a main entry (drives outputs) plus one skid entry; in_ready SHALL equal ~skid_full, registered (no combinational path from out_ready).
REQ-028 Accept with main empty or main consumed same cycle: load main. Accept with main full and not consumed: load skid.
REQ-029 Main consumed and skid full: skid moves to main, skid empties; order SHALL be preserved (FIFO).
REQ-030 Simultaneous accept and consume with skid empty: main reloads with new entry, out_valid stays 1.
REQ-031 Outputs SHALL be stable while out_valid & ~out_ready.
REQ-032 flush SHALL empty both entries at the next edge, override any accept or consume that cycle, and leave in_ready=1.
REQ-033 Throughput SHALL be one instruction per cycle when out_ready held 1.

Reset
REQ-034 While rst is high at a clock edge: out_valid=0, skid empty, in_ready=0 during reset then 1 the cycle after rst falls; alu_control_lines=0000, operand1=0, operand2=0, illegal=0.
REQ-035 rst mid-stream SHALL drop held instructions without issuing them; rst has priority over flush.

Verification
REQ-036 R-type SUB: funct7=0100000, funct3=000, rs1=10, rs2=3, out_ready=1 -> next cycle out_valid=1, code 0110, op1=10, op2=3, illegal=0.
REQ-037 I-type SRAI: funct3=101, funct7=0100000, imm=0x405 -> code 1000, op2=5; I-type SLLI with funct7=0100000 -> illegal=1, code 0010, operands 0.
REQ-038 Backpressure: out_ready=0, send A then B -> A held on outputs, in_ready=0 after B; raise out_ready -> A, then B issued in order, in_ready back to 1.
REQ-039 LUI imm=0x12345000 -> code 0010, op1=0, op2=0x12345000; opcode 1100011 -> illegal=1.
REQ-040 flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1, no entry issued.
REQ-041 Streaming 8 back-to-back ADDIs with out_ready=1 -> 8 consecutive out_valid cycles, 1-cycle latency; rst asserted mid-stream -> out_valid=0 next cycle, outputs zero.

Source files
------------

// File: rtl/alu_issue.sv
// ALU issue stage: decodes R-type, I-type and LUI into an ALU opcode plus operands,
// and holds them in a two-entry buffer (main + skid) with a registered in_ready.
module alu_issue #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_control_lines,
  output logic [XLEN-1:0] operand1,
  output logic [XLEN-1:0] operand2,
  output logic            illegal
);

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b1001;
  localparam logic [3:0] ALU_SLTU = 4'b1010;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] F7_0   = 7'b0000000;
  localparam logic [6:0] F7_ALT = 7'b0100000;

  // Payload layout: {code, illegal, operand1, operand2}
  localparam int W = 5 + 2 * XLEN;

  logic [3:0]      w_code;
  logic            w_ill;
  logic [XLEN-1:0] w_op1;
  logic [XLEN-1:0] w_op2;
  logic [XLEN-1:0] w_shamt;
  logic [W-1:0]    w_payload;
  logic            w_acc;
  logic            w_cons;

  logic            r_main_valid;
  logic            r_skid_valid;
  logic            r_in_ready;
  logic [W-1:0]    r_main;
  logic [W-1:0]    r_skid;

  assign w_shamt = {{(XLEN-5){1'b0}}, imm[4:0]};

  always_comb begin
    w_code = ALU_ADD;
    w_ill  = 1'b0;
    w_op1  = rs1_data;
    w_op2  = rs2_data;
    unique case (opcode)
      OP_R: begin
        unique case (funct3)
          3'b000: begin
            if (funct7 == F7_0)        w_code = ALU_ADD;
            else if (funct7 == F7_ALT) w_code = ALU_SUB;
            else                       w_ill  = 1'b1;
          end
          3'b101: begin
            if (funct7 == F7_0)        w_code = ALU_SRL;
            else if (funct7 == F7_ALT) w_code = ALU_SRA;
            else                       w_ill  = 1'b1;
          end
          3'b001: begin w_code = ALU_SLL;  w_ill = (funct7 != F7_0); end
          3'b010: begin w_code = ALU_SLT;  w_ill = (funct7 != F7_0); end
          3'b011: begin w_code = ALU_SLTU; w_ill = (funct7 != F7_0); end
          3'b100: begin w_code = ALU_XOR;  w_ill = (funct7 != F7_0); end
          3'b110: begin w_code = ALU_OR;   w_ill = (funct7 != F7_0); end
          default: begin w_code = ALU_AND; w_ill = (funct7 != F7_0); end
        endcase
      end
      OP_I: begin
        w_op2 = imm;
        unique case (funct3)
          3'b000: w_code = ALU_ADD;
          3'b001: begin
            w_code = ALU_SLL;
            w_op2  = w_shamt;
            w_ill  = (funct7 != F7_0);
          end
          3'b101: begin
            w_op2 = w_shamt;
            if (funct7 == F7_0)        w_code = ALU_SRL;
            else if (funct7 == F7_ALT) w_code = ALU_SRA;
            else                       w_ill  = 1'b1;
          end
          3'b010: w_code = ALU_SLT;
          3'b011: w_code = ALU_SLTU;
          3'b100: w_code = ALU_XOR;
          3'b110: w_code = ALU_OR;
          default: w_code = ALU_AND;
        endcase
      end
      OP_LUI: begin
        w_op1 = '0;
        w_op2 = imm;
      end
      default: w_ill = 1'b1;
    endcase
    // Illegal instructions still flow downstream, but as a harmless ADD 0,0
    if (w_ill) begin
      w_code = ALU_ADD;
      w_op1  = '0;
      w_op2  = '0;
    end
  end

  assign w_payload = {w_code, w_ill, w_op1, w_op2};
  assign w_acc     = in_valid & r_in_ready;
  assign w_cons    = r_main_valid & out_ready;

  // in_ready is kept equal to ~skid_full, so an accept never meets a full skid
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b0;
      r_main       <= '0;
      r_skid       <= '0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
      r_main       <= '0;
      r_skid       <= '0;
    end else begin
      r_in_ready <= ~r_skid_valid;
      if (!r_main_valid || w_cons) begin
        if (r_skid_valid) begin
          r_main       <= r_skid;
          r_main_valid <= 1'b1;
          r_skid_valid <= 1'b0;
          r_in_ready   <= 1'b1;
        end else if (w_acc) begin
          r_main       <= w_payload;
          r_main_valid <= 1'b1;
        end else begin
          r_main_valid <= 1'b0;
        end
      end else if (w_acc) begin
        r_skid       <= w_payload;
        r_skid_valid <= 1'b1;
        r_in_ready   <= 1'b0;
      end
    end
  end

  assign in_ready          = r_in_ready;
  assign out_valid         = r_main_valid;
  assign alu_control_lines = r_main[W-1 -: 4];
  assign illegal           = r_main[2*XLEN];
  assign operand1          = r_main[2*XLEN-1 -: XLEN];
  assign operand2          = r_main[XLEN-1:0];

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: reference decoder feeds a scoreboard queue on
// input handshakes; the monitor pops and compares on output handshakes.
module tb_alu_issue;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [3:0]      code;
    logic            ill;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] imm;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      alu_control_lines;
  logic [XLEN-1:0] operand1;
  logic [XLEN-1:0] operand2;
  logic            illegal;

  int n_cmp = 0;
  int n_err = 0;
  int n_issued = 0;
  exp_t sb_q[$];

  alu_issue #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_control_lines(alu_control_lines), .operand1(operand1),
    .operand2(operand2), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t ref_decode(input logic [6:0] op, input logic [2:0] f3,
                                      input logic [6:0] f7, input logic [XLEN-1:0] a,
                                      input logic [XLEN-1:0] b, input logic [XLEN-1:0] im);
    exp_t e;
    logic [3:0] tbl [8];
    tbl = '{4'b0010, 4'b0101, 4'b1001, 4'b1010, 4'b0100, 4'b0111, 4'b0001, 4'b0000};
    e.code = tbl[f3];
    e.ill  = 1'b0;
    e.op1  = a;
    e.op2  = b;
    if (op == 7'b0110011) begin
      if (f7 == 7'b0100000 && f3 == 3'b000)      e.code = 4'b0110;
      else if (f7 == 7'b0100000 && f3 == 3'b101) e.code = 4'b1000;
      else if (f7 != 7'b0000000)                 e.ill  = 1'b1;
    end else if (op == 7'b0010011) begin
      e.op2 = im;
      if (f3 == 3'b001 || f3 == 3'b101) begin
        e.op2 = {27'd0, im[4:0]};
        if (f3 == 3'b101 && f7 == 7'b0100000) e.code = 4'b1000;
        else if (f7 != 7'b0000000)            e.ill  = 1'b1;
      end
    end else if (op == 7'b0110111) begin
      e.code = 4'b0010;
      e.op1  = '0;
      e.op2  = im;
    end else begin
      e.ill = 1'b1;
    end
    if (e.ill) begin
      e.code = 4'b0010;
      e.op1  = '0;
      e.op2  = '0;
    end
    return e;
  endfunction

  // Monitor: compare on output handshake first, then record any new input handshake
  always @(negedge clk) begin
    if (rst || flush) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_issued++;
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_issue", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("sb_code", {28'd0, alu_control_lines}, {28'd0, e.code});
          chk("sb_illegal", {31'd0, illegal}, {31'd0, e.ill});
          chk("sb_op1", operand1, e.op1);
          chk("sb_op2", operand2, e.op2);
        end
      end
      if (in_valid && in_ready)
        sb_q.push_back(ref_decode(opcode, funct3, funct7, rs1_data, rs2_data, imm));
    end
  end

  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                      input logic [XLEN-1:0] im);
    int cnt;
    @(posedge clk); #1;
    in_valid = 1'b1; opcode = op; funct3 = f3; funct7 = f7;
    rs1_data = a; rs2_data = b; imm = im;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!in_ready && cnt < 50);
    if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int seen;
    int first;
    rst = 1'b1; in_valid = 1'b0; opcode = '0; funct3 = '0; funct7 = '0;
    rs1_data = '0; rs2_data = '0; imm = '0; flush = 1'b0; out_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_code", {28'd0, alu_control_lines}, 32'd0);
    chk("rst_op1", operand1, 32'd0);
    chk("rst_op2", operand2, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready_hold", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

    // SUB with 1-cycle latency
    out_ready = 1'b1;
    send(7'b0110011, 3'b000, 7'b0100000, 32'd10, 32'd3, 32'd0);
    @(negedge clk);
    chk("sub_valid", {31'd0, out_valid}, 32'd1);
    chk("sub_code", {28'd0, alu_control_lines}, 32'h6);
    chk("sub_op1", operand1, 32'd10);
    chk("sub_op2", operand2, 32'd3);
    chk("sub_illegal", {31'd0, illegal}, 32'd0);

    // I-type shifts, legal and illegal
    send(7'b0010011, 3'b101, 7'b0100000, 32'h8000_0000, 32'd7, 32'h405);
    @(negedge clk);
    chk("srai_code", {28'd0, alu_control_lines}, 32'h8);
    chk("srai_op2", operand2, 32'd5);
    send(7'b0010011, 3'b001, 7'b0100000, 32'd99, 32'd7, 32'h3);
    @(negedge clk);
    chk("slli_bad_illegal", {31'd0, illegal}, 32'd1);
    chk("slli_bad_op1", operand1, 32'd0);

    // Broad R/I-type sweep through the scoreboard
    for (int f = 0; f < 8; f++) begin
      send(7'b0110011, 3'(f), 7'b0000000, 32'h1234 + f, 32'h55 * f, 32'd0);
      send(7'b0110011, 3'(f), 7'b0100000, 32'hAA00 + f, 32'h11, 32'd0);
      send(7'b0110011, 3'(f), 7'b0000001, 32'd1, 32'd2, 32'd0);
      send(7'b0010011, 3'(f), 7'b0000000, 32'd77, 32'd5, 32'hFFFF_FFE3);
      send(7'b0010011, 3'(f), 7'b0100000, 32'd78, 32'd6, 32'h0000_0427);
    end

    // LUI and a non-ALU opcode
    send(7'b0110111, 3'b000, 7'b0000000, 32'hDEAD, 32'hBEEF, 32'h1234_5000);
    @(negedge clk);
    chk("lui_code", {28'd0, alu_control_lines}, 32'h2);
    chk("lui_op1", operand1, 32'd0);
    chk("lui_op2", operand2, 32'h1234_5000);
    send(7'b1100011, 3'b000, 7'b0000000, 32'd1, 32'd2, 32'd3);
    @(negedge clk);
    chk("branch_illegal", {31'd0, illegal}, 32'd1);

    // Backpressure: A stays on outputs, B waits in skid
    @(posedge clk); #1; out_ready = 1'b0;
    send(7'b0110011, 3'b000, 7'b0000000, 32'hA1, 32'hA2, 32'd0);
    send(7'b0110011, 3'b100, 7'b0000000, 32'hB1, 32'hB2, 32'd0);
    @(negedge clk);
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    chk("bp_valid", {31'd0, out_valid}, 32'd1);
    repeat (3) @(negedge clk);
    chk("bp_hold_op1", operand1, 32'hA1);
    chk("bp_hold_code", {28'd0, alu_control_lines}, 32'h2);
    @(posedge clk); #1; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_second_op1", operand1, 32'hB1);
    chk("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // Flush with both entries full and a new instruction offered
    @(posedge clk); #1; out_ready = 1'b0;
    send(7'b0110011, 3'b110, 7'b0000000, 32'hC1, 32'hC2, 32'd0);
    send(7'b0110011, 3'b111, 7'b0000000, 32'hD1, 32'hD2, 32'd0);
    in_valid = 1'b1; opcode = 7'b0010011; funct3 = 3'b000; rs1_data = 32'hE1; imm = 32'd1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("flush_nothing_issued", {31'd0, out_valid}, 32'd0);

    // Streaming 8 ADDIs back to back
    seen = 0; first = -1;
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      if (i < 8) begin
        in_valid = 1'b1; opcode = 7'b0010011; funct3 = 3'b000; funct7 = 7'(i);
        rs1_data = 32'(i * 100); imm = 32'(i + 1);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (i < 8 && !in_ready) chk("stream_in_ready", 32'd0, 32'd1);
      if (out_valid) begin
        seen++;
        if (first < 0) first = i;
      end
    end
    chk("stream_count", 32'(seen), 32'd8);
    chk("stream_latency", 32'(first), 32'd1);

    // Reset mid-stream drops held work
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; opcode = 7'b0010011; funct3 = 3'b100; rs1_data = 32'(i + 7); imm = 32'hF0;
    end
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_code", {28'd0, alu_control_lines}, 32'd0);
    chk("midrst_op1", operand1, 32'd0);
    chk("midrst_op2", operand2, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0; rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_no_issue", {31'd0, out_valid}, 32'd0);
    chk("sb_leftover", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected the run to finish");
    $fatal(1);
  end

endmodule
